// File: rtl/hsv_track_pkg.sv
// Shared types and widths for the HSV colour-blob centroid tracker.
package hsv_track_pkg;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned FRAME_W   = 1024;
    localparam int unsigned FRAME_H   = 768;
    localparam int unsigned X_W       = $clog2(FRAME_W) + 1;
    localparam int unsigned Y_W       = $clog2(FRAME_H);
    localparam int unsigned SUM_W     = 30;
    localparam int unsigned CNT_W     = 20;
    localparam int unsigned DIV_ITERS = SUM_W;
    localparam int unsigned LEFT_W    = $clog2(DIV_ITERS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV_X = 2'd1,
        DIV_Y = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [SUM_W-1:0] sum_x;
        logic [SUM_W-1:0] sum_y;
        logic [CNT_W-1:0] count;
    } accum_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; the start edge already produces the first bit.
module seq_divider
    import hsv_track_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic [SUM_W-1:0] quotient,
    output logic             done
);

    logic [CNT_W-1:0]  rem;
    logic [CNT_W-1:0]  rem_in;
    logic [CNT_W-1:0]  rem_nxt;
    logic [CNT_W-1:0]  dsr;
    logic [CNT_W-1:0]  dsr_in;
    logic [SUM_W-1:0]  dvd;
    logic [SUM_W-1:0]  dvd_in;
    logic [SUM_W-1:0]  dvd_nxt;
    logic [SUM_W-1:0]  quo_nxt;
    logic [CNT_W:0]    shifted;
    logic [CNT_W:0]    trial;
    logic              qbit;
    logic [LEFT_W-1:0] left;
    logic              running;

    // One restoring step; a start restarts from the new operands.
    always_comb begin
        rem_in  = start ? '0 : rem;
        dvd_in  = start ? dividend : dvd;
        dsr_in  = start ? divisor : dsr;
        shifted = {rem_in, dvd_in[SUM_W-1]};
        trial   = shifted - {1'b0, dsr_in};
        qbit    = ~trial[CNT_W];
        rem_nxt = qbit ? trial[CNT_W-1:0] : shifted[CNT_W-1:0];
        dvd_nxt = {dvd_in[SUM_W-2:0], 1'b0};
        quo_nxt = start ? SUM_W'(qbit) : {quotient[SUM_W-2:0], qbit};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rem      <= '0;
            dsr      <= '0;
            dvd      <= '0;
            quotient <= '0;
            left     <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start || running) begin
                rem      <= rem_nxt;
                dsr      <= dsr_in;
                dvd      <= dvd_nxt;
                quotient <= quo_nxt;
            end
            if (start) begin
                left    <= LEFT_W'(DIV_ITERS - 1);
                running <= 1'b1;
            end else if (running) begin
                left <= left - LEFT_W'(1);
                if (left == LEFT_W'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hsv_blob_centroid.sv
// Per-pixel HSV colour match with per-frame centroid of matched pixels.
module hsv_blob_centroid
    import hsv_track_pkg::*;
#(
    parameter logic [PIX_W-1:0] H_LO      = 8'd0,
    parameter logic [PIX_W-1:0] H_HI      = 8'd20,
    parameter logic [PIX_W-1:0] S_MIN     = 8'd100,
    parameter logic [PIX_W-1:0] V_MIN     = 8'd60,
    parameter logic [CNT_W-1:0] MIN_COUNT = 20'd64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [PIX_W-1:0] h,
    input  logic [PIX_W-1:0] s,
    input  logic [PIX_W-1:0] v,
    input  logic             pix_valid,
    input  logic [X_W-1:0]   x,
    input  logic [Y_W-1:0]   y,
    input  logic             frame_end,
    output logic             match,
    output logic [X_W-1:0]   cx,
    output logic [Y_W-1:0]   cy,
    output logic             found,
    output logic             result_valid,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    accum_t           acc;
    accum_t           snap;
    logic             hue_ok_c;
    logic             match_c;
    logic             enough_c;
    logic             accept_c;
    logic             div_start_c;
    logic [SUM_W-1:0] div_dividend_c;
    logic [CNT_W-1:0] div_divisor_c;
    logic             load_cx_c;
    logic             load_cy_c;
    logic             publish_c;
    logic             x_go;
    logic             div_done;
    logic [SUM_W-1:0] quotient;
    logic [X_W-1:0]   cx_sh;
    logic [Y_W-1:0]   cy_sh;

    // Modular distance from H_LO covers both plain and wrapped hue windows.
    assign hue_ok_c = PIX_W'(h - H_LO) <= PIX_W'(H_HI - H_LO);
    assign match_c  = pix_valid && hue_ok_c && (s >= S_MIN) && (v >= V_MIN);
    assign enough_c = acc.count >= MIN_COUNT;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_end) state_nxt = enough_c ? DIV_X : DONE;
            DIV_X:   if (div_done) state_nxt = DIV_Y;
            DIV_Y:   if (div_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Y division is chained onto the same edge that retires the X division.
    always_comb begin
        accept_c       = 1'b0;
        div_start_c    = 1'b0;
        div_dividend_c = snap.sum_x;
        div_divisor_c  = snap.count;
        load_cx_c      = 1'b0;
        load_cy_c      = 1'b0;
        publish_c      = 1'b0;
        case (state)
            IDLE:  accept_c = frame_end;
            DIV_X: begin
                div_start_c = x_go || div_done;
                load_cx_c   = div_done;
                if (div_done) begin
                    div_dividend_c = snap.sum_y;
                end
            end
            DIV_Y: load_cy_c = div_done;
            DONE:  publish_c = 1'b1;
            default: ;
        endcase
    end

    // A pixel sampled with frame_end belongs to the next frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc  <= '0;
            snap <= '0;
        end else begin
            if (accept_c) begin
                snap <= acc;
            end
            if (frame_end) begin
                acc <= match_c ? {SUM_W'(x), SUM_W'(y), CNT_W'(1)} : '0;
            end else if (match_c) begin
                acc.sum_x <= acc.sum_x + SUM_W'(x);
                acc.sum_y <= acc.sum_y + SUM_W'(y);
                acc.count <= acc.count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            match        <= 1'b0;
            x_go         <= 1'b0;
            cx_sh        <= '0;
            cy_sh        <= '0;
            cx           <= '0;
            cy           <= '0;
            found        <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            match        <= match_c;
            x_go         <= accept_c && enough_c;
            result_valid <= publish_c;
            busy         <= state_nxt != IDLE;
            // Clamp only matters for out-of-range coordinates.
            if (load_cx_c) begin
                cx_sh <= (|quotient[SUM_W-1:X_W]) ? '1 : quotient[X_W-1:0];
            end
            if (load_cy_c) begin
                cy_sh <= (|quotient[SUM_W-1:Y_W]) ? '1 : quotient[Y_W-1:0];
            end
            if (publish_c) begin
                found <= snap.count >= MIN_COUNT;
                if (snap.count >= MIN_COUNT) begin
                    cx <= cx_sh;
                    cy <= cy_sh;
                end
            end
        end
    end

    seq_divider u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start_c),
        .dividend (div_dividend_c),
        .divisor  (div_divisor_c),
        .quotient (quotient),
        .done     (div_done)
    );

endmodule

// File: tb/tb_hsv_blob_centroid.sv
// Randomised bench for hsv_blob_centroid against a frame-level behavioural model.
module tb_hsv_blob_centroid;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  h = '0, s = '0, v = '0;
    logic        pix_valid = 1'b0;
    logic [10:0] x = '0;
    logic [9:0]  y = '0;
    logic        frame_end = 1'b0;

    logic        match, found, result_valid, busy;
    logic [10:0] cx;
    logic [9:0]  cy;
    logic        w_match, w_found, w_result_valid, w_busy;
    logic [10:0] w_cx;
    logic [9:0]  w_cy;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int     edge_n = 0;
    longint acc_x = 0, acc_y = 0;
    int     acc_n = 0;
    bit     pend = 0, pend_found = 0, m_busy = 0, m_found = 0, exp_rv = 0;
    int     pend_cx = 0, pend_cy = 0, m_cx = 0, m_cy = 0, res_edge = 0;
    int     rv_cnt = 0, rv_edge = 0, fe_cyc = 0;
    int     hb[8] = '{0, 20, 21, 255, 240, 239, 10, 11};

    localparam int MIN_N = 64;

    always #5 clock = ~clock;

    hsv_blob_centroid dut (
        .clock(clock), .reset(reset), .h(h), .s(s), .v(v), .pix_valid(pix_valid),
        .x(x), .y(y), .frame_end(frame_end), .match(match), .cx(cx), .cy(cy),
        .found(found), .result_valid(result_valid), .busy(busy)
    );

    hsv_blob_centroid #(.H_LO(8'd240), .H_HI(8'd10)) dut_w (
        .clock(clock), .reset(reset), .h(h), .s(s), .v(v), .pix_valid(pix_valid),
        .x(x), .y(y), .frame_end(frame_end), .match(w_match), .cx(w_cx), .cy(w_cy),
        .found(w_found), .result_valid(w_result_valid), .busy(w_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic bit ref_match(input logic [7:0] hh, input logic [7:0] ss,
                                     input logic [7:0] vv, input logic val,
                                     input int lo, input int hi);
        bit hue;
        if (lo <= hi) hue = (int'(hh) >= lo) && (int'(hh) <= hi);
        else          hue = (int'(hh) >= lo) || (int'(hh) <= hi);
        return val && hue && (ss >= 8'd100) && (vv >= 8'd60);
    endfunction

    // Advance one clock, update the model for that edge, compare every output.
    task automatic tick();
        bit mm, mw;
        mm = ref_match(h, s, v, pix_valid, 0, 20);
        mw = ref_match(h, s, v, pix_valid, 240, 10);
        @(posedge clock);
        #1;
        edge_n++;
        exp_rv = 1'b0;
        if (reset) begin
            acc_x = 0; acc_y = 0; acc_n = 0;
            pend = 0; m_busy = 0; m_found = 0; m_cx = 0; m_cy = 0;
            mm = 0; mw = 0;
        end else begin
            if (frame_end && !m_busy) begin
                pend       = 1;
                pend_found = (acc_n >= MIN_N);
                if (pend_found) begin
                    pend_cx  = int'(acc_x / acc_n);
                    pend_cy  = int'(acc_y / acc_n);
                    res_edge = edge_n + 62;
                end else begin
                    res_edge = edge_n + 1;
                end
            end
            if (pend && edge_n == res_edge) begin
                exp_rv  = 1;
                pend    = 0;
                m_found = pend_found;
                if (pend_found) begin
                    m_cx = pend_cx;
                    m_cy = pend_cy;
                end
            end
            if (frame_end) begin
                acc_x = 0; acc_y = 0; acc_n = 0;
            end
            if (mm) begin
                acc_x += longint'(x);
                acc_y += longint'(y);
                acc_n++;
            end
            m_busy = pend && (edge_n < res_edge);
        end
        if (result_valid === 1'b1) begin
            rv_cnt++;
            rv_edge = edge_n;
        end
        chk("match", match, mm);
        chk("match_wrap", w_match, mw);
        chk("result_valid", result_valid, exp_rv);
        chk("busy", busy, m_busy);
        chk("cx", cx, m_cx);
        chk("cy", cy, m_cy);
        chk("found", found, m_found);
    endtask

    task automatic drive(input int hh, input int ss, input int vv, input bit val,
                         input int xx, input int yy, input bit fe);
        h = 8'(hh); s = 8'(ss); v = 8'(vv); pix_valid = val;
        x = 11'(xx); y = 10'(yy); frame_end = fe;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic hit(input bit fe);
        drive(int'($urandom_range(0, 20)), int'($urandom_range(100, 255)),
              int'($urandom_range(60, 255)), 1, int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 767)), fe);
    endtask

    // Pixels that never match the default window.
    task automatic noise();
        int rx, ry;
        rx = int'($urandom_range(0, 1023));
        ry = int'($urandom_range(0, 767));
        case ($urandom_range(0, 3))
            0: drive(int'($urandom_range(21, 239)), 200, 200, 1, rx, ry, 0);
            1: drive(10, int'($urandom_range(0, 99)), 200, 1, rx, ry, 0);
            2: drive(10, 200, int'($urandom_range(0, 59)), 1, rx, ry, 0);
            default: drive(10, 200, 200, 0, rx, ry, 0);
        endcase
    endtask

    task automatic rand_pix(input bit fe);
        int hh, ss, vv;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: hh = int'($urandom_range(0, 255));
            4:          hh = hb[$urandom_range(0, 7)];
            default:    hh = int'($urandom_range(0, 20));
        endcase
        ss = ($urandom_range(0, 3) == 0) ? int'($urandom_range(99, 100)) : int'($urandom_range(90, 255));
        vv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(59, 60)) : int'($urandom_range(50, 255));
        drive(hh, ss, vv, $urandom_range(0, 9) != 0, int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 767)), fe);
    endtask

    initial begin
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(2);

        // 8x8 square at (100..107, 200..207) with interleaved non-matching pixels
        for (int yy = 200; yy < 208; yy++) begin
            for (int xx = 100; xx < 108; xx++) begin
                drive(int'($urandom_range(0, 20)), int'($urandom_range(100, 255)),
                      int'($urandom_range(60, 255)), 1, xx, yy, 0);
                if ($urandom_range(0, 1) == 1) noise();
            end
        end
        fe_cyc = edge_n;
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(70);
        chk("square_cx", cx, 103);
        chk("square_cy", cy, 203);
        chk("square_found", found, 1);
        chk("latency_found", rv_edge - fe_cyc, 63);

        // Too few matches: no detection, centroid held
        for (int i = 0; i < 10; i++) begin
            hit(0);
            noise();
        end
        fe_cyc = edge_n;
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(6);
        chk("few_found", found, 0);
        chk("few_cx_held", cx, 103);
        chk("few_cy_held", cy, 203);
        chk("latency_not_found", rv_edge - fe_cyc, 2);

        // Wrapped-window hues and saturation/value thresholds
        drive(250, 200, 200, 1, 10, 10, 0);
        chk("wrap_h250", w_match, 1);
        drive(5, 200, 200, 1, 10, 10, 0);
        chk("wrap_h5", w_match, 1);
        drive(128, 200, 200, 1, 10, 10, 0);
        chk("wrap_h128", w_match, 0);
        drive(10, 99, 200, 1, 10, 10, 0);
        chk("s99", match, 0);
        drive(10, 200, 59, 1, 10, 10, 0);
        chk("v59", match, 0);
        drive(20, 100, 60, 1, 10, 10, 0);
        chk("edge_in", match, 1);
        drive(21, 100, 60, 1, 10, 10, 0);
        chk("edge_out", match, 0);

        // Second frame_end mid-division is dropped; next frame starts from zero
        for (int i = 0; i < 70; i++) hit(0);
        drive(0, 0, 0, 0, 0, 0, 1);
        rv_cnt = 0;
        for (int i = 0; i < 20; i++) hit(0);
        hit(1);
        for (int i = 0; i < 30; i++) hit(0);
        idle(50);
        chk("one_result", rv_cnt, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(70);

        // Random frames, some frame_end pulses landing while busy
        for (int f = 0; f < 6; f++) begin
            int n;
            n = int'($urandom_range(40, 200));
            for (int i = 0; i < n; i++) rand_pix($urandom_range(0, 60) == 0);
            rand_pix(1);
            idle(int'($urandom_range(0, 80)));
        end
        idle(70);

        // Reset while dividing Y aborts with no result
        for (int i = 0; i < 80; i++) hit(0);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(45);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        rv_cnt = 0;
        idle(70);
        chk("rst_no_result", rv_cnt, 0);
        chk("rst_cx", cx, 0);
        chk("rst_cy", cy, 0);
        chk("rst_found", found, 0);
        chk("rst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hsv_blob_centroid.md
HSV_BLOB_CENTROID -- requirements
Module: hsv_blob_centroid

Interface -- parameters
REQ-001 SHALL have H_LO, default 8'd0; inclusive lower hue bound of the target colour window.
REQ-002 SHALL have H_HI, default 8'd20; inclusive upper hue bound. H_LO > H_HI means the window wraps through 255/0.
REQ-003 SHALL have S_MIN, default 8'd100; minimum saturation for a match.
REQ-004 SHALL have V_MIN, default 8'd60; minimum value for a match.
REQ-005 SHALL have MIN_COUNT, default 20'd64; minimum matched-pixel count for a valid detection.

Interface -- ports
REQ-006 SHALL have port clock, input, 1; the single system clock.
REQ-007 SHALL have port reset, input, 1; synchronous, active-high.
REQ-008 SHALL have port h / s / v, input, 8 each; HSV pixel from the rgb2hsv stage.
REQ-009 SHALL have port pix_valid, input, 1; h/s/v/x/y are valid this cycle.
REQ-010 SHALL have port x, input, 11; pixel column aligned with h/s/v, range 0..1023.
REQ-011 SHALL have port y, input, 10; pixel row aligned with h/s/v, range 0..767.
REQ-012 SHALL have port frame_end, input, 1; one-cycle pulse after the last pixel of a frame.
REQ-013 SHALL have port match, output, 1; registered per-pixel match flag, used for the overlay.
REQ-014 SHALL have port cx, output, 11; centroid column.
REQ-015 SHALL have port cy, output, 10; centroid row.
REQ-016 SHALL have port found, output, 1; the last completed frame met MIN_COUNT.
REQ-017 SHALL have port result_valid, output, 1; one-cycle pulse when cx/cy/found update.
REQ-018 SHALL have port busy, output, 1; division in progress.

Function
REQ-019 Hue test, non-wrapped window (H_LO<=H_HI): match SHALL require H_LO<=h<=H_HI.
REQ-020 Hue test, wrapped window (H_LO>H_HI): match SHALL require h>=H_LO or h<=H_HI.
REQ-021 Match SHALL also require s>=S_MIN and v>=V_MIN and pix_valid=1; match SHALL be output one cycle after the inputs.
REQ-022 Each matched pixel SHALL add x to sum_x (30b), add y to sum_y (30b) and add 1 to count (20b), one cycle after input; widths SHALL not overflow for a 1024x768 frame.
REQ-023 On frame_end, the block SHALL snapshot sum_x/sum_y/count, and clear the accumulators on the same edge. A match landing on that same edge SHALL count toward the new frame.
REQ-024 FSM states SHALL be IDLE, DIV_X, DIV_Y, DONE.
REQ-025 IDLE->DIV_X on frame_end when count snapshot >= MIN_COUNT.
REQ-026 IDLE->DONE on frame_end when count snapshot < MIN_COUNT; found SHALL go 0 and cx/cy SHALL hold their values.
REQ-027 DIV_X and DIV_Y SHALL each run one restoring divide, sum/count, 30b/20b, 30 iterations at one quotient bit per cycle, through a shared divider instance.
REQ-028 DIV_X->DIV_Y when the divider finishes, latching quotient[10:0] into a cx shadow register.
REQ-029 DIV_Y->DONE when the divider finishes, latching quotient[9:0] into a cy shadow register.
REQ-030 DONE SHALL update cx/cy/found together, pulse result_valid for one cycle, then return to IDLE.
REQ-031 Latency from frame_end to result_valid SHALL be 63 cycles when found, and 2 cycles when not found.
REQ-032 busy SHALL be high in DIV_X, DIV_Y and DONE.
REQ-033 A frame_end while busy SHALL still clear the accumulators, but its snapshot SHALL be discarded with no result for that frame. The running division SHALL be unaffected.
REQ-034 Pixel accumulation SHALL continue during division.

Reset
REQ-035 Reset SHALL clear: the accumulators, the snapshots, cx=0, cy=0, found=0, match=0, result_valid=0, busy=0, and set FSM=IDLE.
REQ-036 Reset asserted mid-division SHALL abort it with no result_valid pulse.

Structure
REQ-037 Package hsv_track_pkg SHALL hold: the FSM state typedef, the accumulator widths (SUM_W=30, CNT_W=20), and the frame dimensions (1024, 768).
REQ-038 Sub-module seq_divider SHALL have ports start, dividend, divisor, quotient and done. It SHALL be restoring, 30 cycles, and synchronously reset.

Verification
REQ-039 Window H=[0,20], S_MIN=100, V_MIN=60; an 8x8 matching square at x 100..107, y 200..207 -> count 64, cx=103, cy=203, found=1, result_valid 63 cycles after frame_end.
REQ-040 Wrapped window H_LO=240, H_HI=10; pixels with h=250 and h=5 -> match=1; h=128 -> match=0.
REQ-041 Only 10 matched pixels -> found=0, result_valid 2 cycles after frame_end, cx/cy unchanged.
REQ-042 s=99 or v=59 with an in-window hue -> match=0 and count unchanged.
REQ-043 Second frame_end 20 cycles into a division -> exactly one result_valid, carrying the first frame's values; the next frame accumulates from zero.
REQ-044 Reset during DIV_Y -> no result_valid, all outputs 0, FSM=IDLE.
